foc_stage_sequencer: RTL

Control-loop sequencer for the FOC datapath. Each PWM period it walks a fixed chain of pipeline stages in order: Clark, Park, PI, inverse Park, inverse Clark and SVPWM. For each stage it issues a one-cycle start pulse on that stage's enable, then waits for the stage's one-cycle done pulse. It sits between the ADC sample strobe and the stage blocks, and it reports loop completion, overruns and stalled stages to the top level.

---
 rtl/foc_stage_sequencer_if.sv | 42 ++++
 rtl/foc_stage_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/foc_stage_sequencer_if.sv
// Handshake bundle between the FOC stage sequencer and the control-loop top:
// the loop trigger, per-stage start/done pulses, and the status it reports.
interface foc_stage_sequencer_if #(
    parameter int NUM_STAGES = 6,
    parameter int IDX_W      = 3
);
    logic                  iTrig;
    logic [NUM_STAGES-1:0] iStage_done;
    logic                  iFault_clr;
    logic [NUM_STAGES-1:0] oStage_en;
    logic [IDX_W-1:0]      oStage_idx;
    logic                  oBusy;
    logic                  oCycle_done;
    logic                  oFault;
    logic [7:0]            oOverrun_cnt;

    // Control top / stage blocks: drive trigger, done pulses and fault clear.
    modport master (
        output iTrig,
        output iStage_done,
        output iFault_clr,
        input  oStage_en,
        input  oStage_idx,
        input  oBusy,
        input  oCycle_done,
        input  oFault,
        input  oOverrun_cnt
    );

    // Sequencer side.
    modport slave (
        input  iTrig,
        input  iStage_done,
        input  iFault_clr,
        output oStage_en,
        output oStage_idx,
        output oBusy,
        output oCycle_done,
        output oFault,
        output oOverrun_cnt
    );
endinterface

// File: rtl/foc_stage_sequencer.sv
// FOC control-loop sequencer: on each ADC trigger it walks the stage chain
// (Clark, Park, PI, inverse Park, inverse Clark, SVPWM), pulsing each stage's
// enable and waiting for its done pulse, with a per-stage stall timeout,
// a latched fault and a saturating count of triggers dropped while busy.
module foc_stage_sequencer #(
    parameter int NUM_STAGES = 6,
    parameter int IDX_W      = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    foc_stage_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_STAGES - 1);
    localparam logic [7:0]       TIMEOUT_VAL = 8'(TIMEOUT);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            timer_q, timer_d;
    logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
    logic                  busy_q, busy_d;
    logic                  cycle_done_q, cycle_done_d;
    logic                  fault_q, fault_d;
    logic [7:0]            overrun_q, overrun_d;
    logic                  done_sel;
    logic                  issue;

    // Next state, next index/timer and the registered pulse outputs; only the done bit of the awaited stage counts.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        issue        = 1'b0;
        cycle_done_d = 1'b0;
        stage_en_d   = '0;
        overrun_d    = overrun_q;
        done_sel     = 1'b0;

        for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                done_sel = bus.iStage_done[k];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.iTrig) begin
                    state_d = ST_WAIT;
                    idx_d   = '0;
                    timer_d = '0;
                    issue   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (done_sel && (idx_q == LAST_IDX)) begin
                    cycle_done_d = 1'b1;
                    state_d      = ST_IDLE;
                    idx_d        = '0;
                end else if (done_sel) begin
                    idx_d   = idx_q + IDX_W'(1);
                    timer_d = '0;
                    issue   = 1'b1;
                end else if (timer_q == TIMEOUT_VAL) begin
                    state_d = ST_FAULT;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_FAULT: begin
                if (bus.iFault_clr) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase

        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_en_d[k] = issue && (idx_d == IDX_W'(k));
        end

        busy_d  = (state_d == ST_WAIT);
        fault_d = (state_d == ST_FAULT);

        if (bus.iFault_clr) begin
            overrun_d = 8'd0;
        end else if (bus.iTrig && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    // State and output registers; an asynchronous reset aborts any loop in flight.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            timer_q      <= 8'd0;
            stage_en_q   <= '0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            fault_q      <= 1'b0;
            overrun_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            stage_en_q   <= stage_en_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
            fault_q      <= fault_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.oStage_en    = stage_en_q;
    assign bus.oStage_idx   = idx_q;
    assign bus.oBusy        = busy_q;
    assign bus.oCycle_done  = cycle_done_q;
    assign bus.oFault       = fault_q;
    assign bus.oOverrun_cnt = overrun_q;

endmodule
